// File: rtl/tag_compare_if.sv
// Bus bundle for tag_compare: tag FIFO pop side, memory-controller tag response
// channel, hit/miss result channel and the statistics counters.
interface tag_compare_if #(
    parameter int ADDR_WIDTH   = 64,
    parameter int TID_WIDTH    = 16,
    parameter int INDEX_WIDTH  = 24,
    parameter int OFFSET_WIDTH = 6,
    parameter int RTAG_WIDTH   = 56,
    parameter int RDATA_WIDTH  = 72,
    parameter int CNT_WIDTH    = 32
) ();
    localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;

    logic                              fifo_aempty_i;
    logic                              fifo_rden_o;
    logic [ADDR_WIDTH+TID_WIDTH:0]     fifo_data_i;
    logic [RTAG_WIDTH-1:0]             rtag_i;
    logic [RDATA_WIDTH-1:0]            rdata_i;
    logic                              rvalid_i;
    logic                              rready_o;
    logic                              res_valid_o;
    logic                              res_ready_i;
    logic                              res_hit_o;
    logic                              res_write_o;
    logic                              res_dirty_o;
    logic [ADDR_WIDTH-1:0]             res_addr_o;
    logic [TID_WIDTH-1:0]              res_tid_o;
    logic [TAG_WIDTH-1:0]              res_victim_tag_o;
    logic [RDATA_WIDTH-1:0]            res_data_o;
    logic [CNT_WIDTH-1:0]              hit_cnt_o;
    logic [CNT_WIDTH-1:0]              miss_cnt_o;

    modport slave (
        input  fifo_aempty_i, fifo_data_i, rtag_i, rdata_i, rvalid_i, res_ready_i,
        output fifo_rden_o, rready_o, res_valid_o, res_hit_o, res_write_o, res_dirty_o,
               res_addr_o, res_tid_o, res_victim_tag_o, res_data_o, hit_cnt_o, miss_cnt_o
    );

    modport master (
        output fifo_aempty_i, fifo_data_i, rtag_i, rdata_i, rvalid_i, res_ready_i,
        input  fifo_rden_o, rready_o, res_valid_o, res_hit_o, res_write_o, res_dirty_o,
               res_addr_o, res_tid_o, res_victim_tag_o, res_data_o, hit_cnt_o, miss_cnt_o
    );
endinterface

// File: rtl/tag_compare.sv
// Tag FIFO consumer: pops one request, waits for its in-order tag response,
// compares tags and presents a hit/miss record; keeps saturating hit/miss counts.
module tag_compare #(
    parameter int ADDR_WIDTH   = 64,
    parameter int TID_WIDTH    = 16,
    parameter int INDEX_WIDTH  = 24,
    parameter int OFFSET_WIDTH = 6,
    parameter int RTAG_WIDTH   = 56,
    parameter int RDATA_WIDTH  = 72,
    parameter int CNT_WIDTH    = 32
) (
    input  logic           clk,
    input  logic           rst,
    tag_compare_if.slave   bus
);
    localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;

    generate
        if (TAG_WIDTH > RTAG_WIDTH - 2) begin : g_bad_tag_width
            $error("tag_compare: TAG_WIDTH exceeds RTAG_WIDTH-2");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_TAG, RESP} state_t;

    state_t                   state_q, state_d;
    logic                     rden, rready, res_valid, load_en, cap_en;

    logic                     req_write_q;
    logic [ADDR_WIDTH-1:0]    req_addr_q;
    logic [TID_WIDTH-1:0]     req_tid_q;
    logic                     hit_q, dirty_q;
    logic [TAG_WIDTH-1:0]     vtag_q;
    logic [RDATA_WIDTH-1:0]   data_q;
    logic [CNT_WIDTH-1:0]     hit_cnt_q, miss_cnt_q;

    logic                     r_vld, r_dirty, tag_hit;
    logic [TAG_WIDTH-1:0]     r_tag, req_tag;
    logic                     unused_rtag_bits;

    assign r_vld   = bus.rtag_i[RTAG_WIDTH-1];
    assign r_dirty = bus.rtag_i[RTAG_WIDTH-2];
    assign r_tag   = bus.rtag_i[TAG_WIDTH-1:0];
    assign req_tag = req_addr_q[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign tag_hit = r_vld && (r_tag == req_tag);
    // Bits between the stored tag and the valid/dirty flags carry nothing here.
    assign unused_rtag_bits = ^bus.rtag_i[RTAG_WIDTH-3:TAG_WIDTH];

    always_comb begin
        state_d   = state_q;
        rden      = 1'b0;
        rready    = 1'b0;
        res_valid = 1'b0;
        load_en   = 1'b0;
        cap_en    = 1'b0;
        case (state_q)
            IDLE: begin
                rden = ~bus.fifo_aempty_i;
                if (!bus.fifo_aempty_i) state_d = LOAD;
            end
            LOAD: begin
                load_en = 1'b1;
                state_d = WAIT_TAG;
            end
            WAIT_TAG: begin
                rready = 1'b1;
                if (bus.rvalid_i) begin
                    cap_en  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                res_valid = 1'b1;
                if (bus.res_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The pop strobe is combinational from IDLE, so it must be forced low while reset is held.
    assign bus.fifo_rden_o = rden & ~rst;
    assign bus.rready_o    = rready;
    assign bus.res_valid_o = res_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            req_write_q <= 1'b0;
            req_addr_q  <= '0;
            req_tid_q   <= '0;
            hit_q       <= 1'b0;
            dirty_q     <= 1'b0;
            vtag_q      <= '0;
            data_q      <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_en) begin
                req_write_q <= bus.fifo_data_i[ADDR_WIDTH+TID_WIDTH];
                req_addr_q  <= bus.fifo_data_i[ADDR_WIDTH+TID_WIDTH-1:TID_WIDTH];
                req_tid_q   <= bus.fifo_data_i[TID_WIDTH-1:0];
            end
            if (cap_en) begin
                hit_q   <= tag_hit;
                dirty_q <= r_vld & ~tag_hit & r_dirty;
                vtag_q  <= r_tag;
                data_q  <= bus.rdata_i;
                if (tag_hit) begin
                    if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
                end else begin
                    if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
                end
            end
        end
    end

    assign bus.res_hit_o        = hit_q;
    assign bus.res_write_o      = req_write_q;
    assign bus.res_dirty_o      = dirty_q;
    assign bus.res_addr_o       = req_addr_q;
    assign bus.res_tid_o        = req_tid_q;
    assign bus.res_victim_tag_o = vtag_q;
    assign bus.res_data_o       = data_q;
    assign bus.hit_cnt_o        = hit_cnt_q;
    assign bus.miss_cnt_o       = miss_cnt_q;
endmodule

// File: tb/tb_tag_compare.sv
// Scoreboard bench for tag_compare: FIFO / R-channel drivers, result monitor,
// and a reference model of the hit/miss rules with 4-bit saturating counters.
module tb_tag_compare;
    localparam int CNTW = 4;
    localparam int CMAX = (1 << CNTW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tag_compare_if #(.CNT_WIDTH(CNTW)) bus ();
    tag_compare #(.CNT_WIDTH(CNTW)) u_dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic        w;
        logic [63:0] addr;
        logic [15:0] tid;
        logic [55:0] rtag;
        logic [71:0] rdata;
        int          stall;
        int          rdelay;
    } req_t;

    typedef struct {
        logic        hit, dirty, w;
        logic [63:0] addr;
        logic [15:0] tid;
        logic [33:0] vtag;
        logic [71:0] data;
        int          hc, mc, stall;
        bit          fast;
    } exp_t;

    req_t fifo_q[$];
    req_t pend_q[$];
    exp_t exp_q[$];
    int   popc_q[$];
    int   tests = 0, fails = 0;
    int   cyc = 0, hc = 0, mc = 0, rd_cnt = 0, wcnt = 0;
    bit   first = 1'b1;

    task automatic chk(input string n, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, got, exp);
        end
    endtask

    // Reference model: the outcome follows from the address and the returned tag word alone.
    task automatic enqueue(input logic w, input logic [63:0] addr, input logic [15:0] tid,
                           input logic v, input logic d, input logic [33:0] tag,
                           input int stall, input int rdelay);
        req_t r; exp_t e; logic [31:0] p; logic [95:0] dat;
        p = $urandom();
        dat = {$urandom(), $urandom(), $urandom()};
        r.w = w; r.addr = addr; r.tid = tid; r.rtag = {v, d, p[19:0], tag};
        r.rdata = dat[71:0]; r.stall = stall; r.rdelay = rdelay;
        e.w = w; e.addr = addr; e.tid = tid; e.vtag = tag; e.data = dat[71:0];
        e.hit = v && (tag == addr[63:30]);
        e.dirty = v && !e.hit && d;
        if (e.hit) hc = (hc < CMAX) ? hc + 1 : CMAX;
        else       mc = (mc < CMAX) ? mc + 1 : CMAX;
        e.hc = hc; e.mc = mc; e.stall = stall; e.fast = (rdelay == 0);
        fifo_q.push_back(r);
        exp_q.push_back(e);
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while ((fifo_q.size() || pend_q.size() || exp_q.size()) && n < max_cyc) begin
            @(negedge clk); n++;
        end
        if (n >= max_cyc) begin
            fails++;
            $display("FAIL drain_timeout: got %0d outstanding expected 0", exp_q.size());
        end
    endtask

    function automatic logic [255:0] all_outs();
        return {bus.fifo_rden_o, bus.rready_o, bus.res_valid_o, bus.res_hit_o, bus.res_write_o,
                bus.res_dirty_o, bus.res_addr_o, bus.res_tid_o, bus.res_victim_tag_o,
                bus.res_data_o, bus.hit_cnt_o, bus.miss_cnt_o};
    endfunction

    initial forever begin
        @(posedge clk); cyc++;
    end

    // Tag FIFO and memory-controller R channel, driven together so ordering is deterministic.
    initial begin
        bit rd, hs; int rdc; req_t r; logic [95:0] j;
        bus.fifo_aempty_i = 1'b1; bus.rvalid_i = 1'b0;
        bus.rtag_i = '0; bus.rdata_i = '0; bus.fifo_data_i = '0;
        forever begin
            @(negedge clk);
            rd = bus.fifo_rden_o; hs = bus.rvalid_i && bus.rready_o; rdc = cyc;
            @(posedge clk); #1;
            if (hs && pend_q.size()) begin
                void'(pend_q.pop_front());
                bus.rvalid_i = 1'b0;
            end
            if (rd && fifo_q.size()) begin
                r = fifo_q.pop_front();
                bus.fifo_data_i = {r.w, r.addr, r.tid};
                pend_q.push_back(r);
                popc_q.push_back(rdc);
            end else begin
                j = {$urandom(), $urandom(), $urandom()};
                bus.fifo_data_i = j[80:0];
            end
            if (!bus.rvalid_i && pend_q.size()) begin
                if (rd_cnt < pend_q[0].rdelay) rd_cnt++;
                else begin
                    bus.rvalid_i = 1'b1;
                    bus.rtag_i = pend_q[0].rtag;
                    bus.rdata_i = pend_q[0].rdata;
                    rd_cnt = 0;
                end
            end
            bus.fifo_aempty_i = (fifo_q.size() == 0);
        end
    end

    // Result consumer: stalls a result for its planned cycles, random ready otherwise.
    initial begin
        bus.res_ready_i = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (bus.res_valid_o) begin
                if (exp_q.size() && wcnt < exp_q[0].stall) begin
                    bus.res_ready_i = 1'b0; wcnt++;
                end else bus.res_ready_i = 1'b1;
            end else begin
                wcnt = 0;
                bus.res_ready_i = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: compares every presented result cycle against the scoreboard head.
    initial forever begin
        exp_t e; int p;
        @(negedge clk);
        if (rst) continue;
        if (bus.res_valid_o) begin
            if (exp_q.size() == 0) chk("spurious_res_valid", 256'(bus.res_valid_o), 256'(0));
            else begin
                e = exp_q[0];
                if (first) begin
                    first = 1'b0;
                    if (popc_q.size()) begin
                        p = popc_q.pop_front();
                        if (e.fast) chk("latency", 256'(cyc - p), 256'(3));
                    end
                end
                chk("res_hit", 256'(bus.res_hit_o), 256'(e.hit));
                chk("res_dirty", 256'(bus.res_dirty_o), 256'(e.dirty));
                chk("res_write", 256'(bus.res_write_o), 256'(e.w));
                chk("res_addr", 256'(bus.res_addr_o), 256'(e.addr));
                chk("res_tid", 256'(bus.res_tid_o), 256'(e.tid));
                chk("res_victim_tag", 256'(bus.res_victim_tag_o), 256'(e.vtag));
                chk("res_data", 256'(bus.res_data_o), 256'(e.data));
                chk("hit_cnt", 256'(bus.hit_cnt_o), 256'(e.hc));
                chk("miss_cnt", 256'(bus.miss_cnt_o), 256'(e.mc));
                chk("quiet_in_resp", 256'({bus.fifo_rden_o, bus.rready_o}), 256'(0));
                if (bus.res_ready_i) begin
                    void'(exp_q.pop_front());
                    first = 1'b1;
                end
            end
        end else if (bus.fifo_rden_o) begin
            chk("single_in_flight", 256'(pend_q.size()), 256'(0));
        end
    end

    initial begin
        int n;
        logic [63:0] a;
        logic [31:0] r1, r2;
        repeat (3) @(negedge clk);
        chk("reset_outputs", all_outs(), 256'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        a = 64'h0000_0001_4000_0040;
        enqueue(1'b0, a, 16'h0012, 1'b1, 1'b0, 34'h5, 0, 0);   // read hit
        drain(200);
        enqueue(1'b0, a, 16'h0013, 1'b1, 1'b1, 34'h7, 0, 0);   // dirty miss
        enqueue(1'b1, a, 16'h0014, 1'b0, 1'b1, 34'h5, 0, 0);   // invalid line
        drain(200);

        enqueue(1'b1, a, 16'h0100, 1'b1, 1'b1, 34'h9, 5, 0);   // back-pressure
        enqueue(1'b0, a, 16'h0101, 1'b1, 1'b0, 34'h5, 0, 0);
        enqueue(1'b0, a, 16'h0102, 1'b1, 1'b0, 34'h5, 2, 1);
        drain(300);

        for (int i = 0; i < 20; i++) begin                      // empty FIFO
            @(negedge clk);
            chk("empty_idle", 256'({bus.fifo_rden_o, bus.rready_o}), 256'(0));
        end

        for (int i = 0; i < 40; i++) begin
            r1 = $urandom(); r2 = $urandom();
            a = {r1, r2};
            enqueue(r1[0], a, r2[15:0], ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 1) ? a[63:30] : {r2[1:0], r1}),
                    $urandom_range(0, 3), $urandom_range(0, 3));
        end
        drain(2000);

        enqueue(1'b0, a, 16'h0abc, 1'b1, 1'b0, a[63:30], 0, 10); // reset in WAIT_TAG
        n = 0;
        while (!bus.rready_o && n < 50) begin @(negedge clk); n++; end
        chk("reached_wait_tag", 256'(bus.rready_o), 256'(1));
        rst = 1'b1;
        fifo_q.delete(); pend_q.delete(); exp_q.delete(); popc_q.delete();
        hc = 0; mc = 0; rd_cnt = 0; first = 1'b1;
        bus.rvalid_i = 1'b0; bus.fifo_aempty_i = 1'b1;
        #1;
        chk("reset_midflight", all_outs(), 256'(0));
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("no_result_after_reset", 256'(bus.res_valid_o), 256'(0));
        end

        for (int i = 0; i < 17; i++) begin                      // saturation
            r1 = $urandom(); r2 = $urandom();
            a = {r1, r2};
            enqueue(1'b0, a, 16'(i), 1'b1, 1'b0, a[63:30], 0, $urandom_range(0, 2));
        end
        drain(1000);
        chk("hit_cnt_saturated", 256'(bus.hit_cnt_o), 256'(CMAX));
        chk("miss_cnt_after_reset", 256'(bus.miss_cnt_o), 256'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
